// File: rtl/paddle_tracker.sv
// paddle_tracker: per-frame left/right paddle centre-row tracking from denoised mask bits.
// Build option PADDLE_SMOOTH_EN averages each detected row with the previous output row.
module paddle_tracker #(
    parameter int MIN_PIXELS  = 16,
    parameter int LOST_FRAMES = 8,
    parameter int CENTER_ROW  = 240,
    parameter int COUNT_WIDTH = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        vs_ni,
    input  logic        blank_ni,
    input  logic        left_paddle,
    input  logic        right_paddle,
    input  logic [12:0] row_i,
    output logic [12:0] left_y,
    output logic [12:0] right_y,
    output logic        left_valid,
    output logic        right_valid,
    output logic        frame_strobe
);

    // state     | meaning
    // WAIT_SYNC | after reset, waiting for the first frame edge (partial frame discarded)
    // ACCUM     | gathering per-side pixel count and row extent for the current frame
    // UPDATE    | one cycle: per-side decision from the closed frame's accumulators
    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACCUM     = 2'd1,
        UPDATE    = 2'd2
    } state_t;

    localparam int MISS_W = $clog2(LOST_FRAMES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MIN = COUNT_WIDTH'(MIN_PIXELS);
    localparam logic [MISS_W-1:0]      MISS_LIM  = MISS_W'(LOST_FRAMES);
    localparam logic [12:0]            ROW_CTR   = 13'(CENTER_ROW);
    localparam logic [12:0]            ROW_TOP   = 13'h1FFF;

    state_t state_q, state_d;
    logic   vs_q;
    logic   frame_edge;
    logic   pixel_ok;
    logic   acc_clear;
    logic   acc_en;
    logic   do_update;
    logic [1:0] mask;

    logic [COUNT_WIDTH-1:0] cnt_q [2];
    logic [12:0]            min_q [2];
    logic [12:0]            max_q [2];

    logic [MISS_W-1:0] miss_q   [2];
    logic [MISS_W-1:0] miss_d   [2];
    logic [12:0]       y_q      [2];
    logic [12:0]       y_d      [2];
    logic              valid_q  [2];
    logic              valid_d  [2];
    logic              detected [2];
    logic [13:0]       row_sum  [2];
    logic [12:0]       y_new    [2];
    logic [12:0]       y_det    [2];
`ifdef PADDLE_SMOOTH_EN
    logic [13:0]       smooth_sum [2];
`endif

    assign frame_edge = vs_q & ~vs_ni;
    assign pixel_ok   = en_i & blank_ni;
    assign mask       = {right_paddle, left_paddle};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q    <= 1'b1;
            state_q <= WAIT_SYNC;
        end else begin
            vs_q    <= vs_ni;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        do_update = 1'b0;
        case (state_q)
            WAIT_SYNC: begin
                if (frame_edge) begin
                    state_d   = ACCUM;
                    acc_clear = 1'b1;
                end
            end
            ACCUM: begin
                // The pixel sharing the closing edge cycle belongs to no frame.
                if (frame_edge) begin
                    state_d = UPDATE;
                end else begin
                    acc_en = pixel_ok;
                end
            end
            UPDATE: begin
                do_update = 1'b1;
                acc_clear = 1'b1;
                state_d   = ACCUM;
            end
            default: begin
                state_d = WAIT_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s] <= '0;
                min_q[s] <= ROW_TOP;
                max_q[s] <= '0;
            end
        end else if (acc_clear) begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s] <= '0;
                min_q[s] <= ROW_TOP;
                max_q[s] <= '0;
            end
        end else if (acc_en) begin
            for (int s = 0; s < 2; s++) begin
                if (mask[s]) begin
                    if (cnt_q[s] != COUNT_MAX) begin
                        cnt_q[s] <= cnt_q[s] + COUNT_WIDTH'(1);
                    end
                    if (row_i < min_q[s]) begin
                        min_q[s] <= row_i;
                    end
                    if (row_i > max_q[s]) begin
                        max_q[s] <= row_i;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            row_sum[s]  = {1'b0, min_q[s]} + {1'b0, max_q[s]};
            y_new[s]    = 13'(row_sum[s] >> 1);
`ifdef PADDLE_SMOOTH_EN
            smooth_sum[s] = {1'b0, y_q[s]} + {1'b0, y_new[s]};
            y_det[s]      = 13'(smooth_sum[s] >> 1);
`else
            y_det[s]      = y_new[s];
`endif
            detected[s] = (cnt_q[s] >= COUNT_MIN);
            valid_d[s]  = 1'b0;
            miss_d[s]   = miss_q[s];
            y_d[s]      = y_q[s];
            if (detected[s]) begin
                valid_d[s] = 1'b1;
                miss_d[s]  = '0;
                y_d[s]     = y_det[s];
            end else begin
                if (miss_q[s] != MISS_LIM) begin
                    miss_d[s] = miss_q[s] + MISS_W'(1);
                end
                // Recentre bypasses smoothing so a lost paddle snaps home.
                if (miss_d[s] == MISS_LIM) begin
                    y_d[s] = ROW_CTR;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_strobe <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                y_q[s]     <= ROW_CTR;
                valid_q[s] <= 1'b0;
                miss_q[s]  <= '0;
            end
        end else begin
            frame_strobe <= do_update;
            if (do_update) begin
                for (int s = 0; s < 2; s++) begin
                    y_q[s]     <= y_d[s];
                    valid_q[s] <= valid_d[s];
                    miss_q[s]  <= miss_d[s];
                end
            end
        end
    end

    assign left_y      = y_q[0];
    assign right_y     = y_q[1];
    assign left_valid  = valid_q[0];
    assign right_valid = valid_q[1];

endmodule

// File: tb/tb_paddle_tracker.sv
// Bench for paddle_tracker: frame-level model checked every cycle, plus literal scenario checks.
// Build with PADDLE_SMOOTH_EN defined to exercise the smoothed variant.
module tb_paddle_tracker;

    localparam int MIN_PIXELS  = 16;
    localparam int LOST_FRAMES = 8;
    localparam int CENTER_ROW  = 240;

`ifdef PADDLE_SMOOTH_EN
    localparam int L_B = 179, R_C = 274, R_B16 = 223, L_F = 170;
`else
    localparam int L_B = 119, R_C = 309, R_B16 = 207, L_F = 100;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en_i = 1'b0;
    logic        vs_ni = 1'b1;
    logic        blank_ni = 1'b1;
    logic        left_paddle = 1'b0;
    logic        right_paddle = 1'b0;
    logic [12:0] row_i = '0;
    logic [12:0] left_y;
    logic [12:0] right_y;
    logic        left_valid;
    logic        right_valid;
    logic        frame_strobe;

    int n_vec = 0;
    int n_err = 0;

    paddle_tracker #(
        .MIN_PIXELS (MIN_PIXELS),
        .LOST_FRAMES(LOST_FRAMES),
        .CENTER_ROW (CENTER_ROW),
        .COUNT_WIDTH(20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en_i),
        .vs_ni       (vs_ni),
        .blank_ni    (blank_ni),
        .left_paddle (left_paddle),
        .right_paddle(right_paddle),
        .row_i       (row_i),
        .left_y      (left_y),
        .right_y     (right_y),
        .left_valid  (left_valid),
        .right_valid (right_valid),
        .frame_strobe(frame_strobe)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Frame-level model: per-side pixel tallies and row extent, decided once per closed frame.
    int  m_cnt [2], m_min [2], m_max [2], m_miss [2];
    int  exp_y [2], pend_y [2];
    bit  exp_v [2], pend_v [2];
    bit  mk    [2];
    bit  exp_s, armed, skip, pend, prev_vs, edge_now;
    int  ny;

    initial begin : model
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                armed = 0; skip = 0; pend = 0; prev_vs = 1; exp_s = 0;
                for (int s = 0; s < 2; s++) begin
                    exp_y[s] = CENTER_ROW; exp_v[s] = 0; m_miss[s] = 0;
                    m_cnt[s] = 0; m_min[s] = 8191; m_max[s] = 0;
                end
            end else begin
                edge_now = prev_vs && !vs_ni;
                exp_s = 0;
                if (pend) begin
                    for (int s = 0; s < 2; s++) begin
                        exp_y[s] = pend_y[s];
                        exp_v[s] = pend_v[s];
                    end
                    exp_s = 1;
                    pend  = 0;
                end
                mk[0] = left_paddle;
                mk[1] = right_paddle;
                if (edge_now) begin
                    if (armed) begin
                        for (int s = 0; s < 2; s++) begin
                            if (m_cnt[s] >= MIN_PIXELS) begin
                                ny = (m_min[s] + m_max[s]) / 2;
`ifdef PADDLE_SMOOTH_EN
                                ny = (exp_y[s] + ny) / 2;
`endif
                                pend_y[s] = ny; pend_v[s] = 1; m_miss[s] = 0;
                            end else begin
                                pend_v[s] = 0;
                                if (m_miss[s] < LOST_FRAMES) m_miss[s]++;
                                pend_y[s] = (m_miss[s] == LOST_FRAMES) ? CENTER_ROW : exp_y[s];
                            end
                        end
                        pend = 1;
                        skip = 1;
                    end
                    armed = 1;
                    for (int s = 0; s < 2; s++) begin
                        m_cnt[s] = 0; m_min[s] = 8191; m_max[s] = 0;
                    end
                end else if (skip) begin
                    skip = 0;
                end else if (armed && en_i && blank_ni) begin
                    for (int s = 0; s < 2; s++) begin
                        if (mk[s]) begin
                            m_cnt[s]++;
                            if (row_i < m_min[s]) m_min[s] = row_i;
                            if (row_i > m_max[s]) m_max[s] = row_i;
                        end
                    end
                end
                prev_vs = vs_ni;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("left_y", left_y, exp_y[0]);
            chk("right_y", right_y, exp_y[1]);
            chk("left_valid", left_valid, exp_v[0]);
            chk("right_valid", right_valid, exp_v[1]);
            chk("frame_strobe", frame_strobe, exp_s);
        end
    end

    task automatic idle();
        en_i = 0; blank_ni = 1; left_paddle = 0; right_paddle = 0; row_i = '0;
    endtask

    // Raster over rows rs..re, 12 columns; col 10 has en_i=0 and col 11 blank_ni=0, both with mask set.
    // mode 1 blanks every pixel, mode 2 disables every pixel.
    task automatic frame(input int rs, input int re, input int llo, input int lhi, input int lc,
                         input int rlo, input int rhi, input int rc, input int mode);
        for (int r = rs; r <= re; r++) begin
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #2;
                row_i        = 13'(r);
                left_paddle  = (r >= llo && r <= lhi && c < lc) || c >= 10;
                right_paddle = (r >= rlo && r <= rhi && c < rc) || c >= 10;
                en_i         = (c != 10) && (mode != 2);
                blank_ni     = (c != 11) && (mode != 1);
            end
        end
        @(posedge clk); #2;
        idle();
    endtask

    // Returns just after the output register write following this edge.
    task automatic vsync_edge();
        vs_ni = 0; en_i = 1; blank_ni = 1; left_paddle = 1; right_paddle = 1; row_i = '0;
        @(posedge clk); #2;
        idle();
        @(posedge clk); #2;
    endtask

    task automatic vsync_end();
        @(posedge clk); #2;
        vs_ni = 1;
        @(posedge clk); #2;
    endtask

    initial begin : stim
        #1 reset = 1;
        repeat (3) @(posedge clk);
        #2 reset = 0;
        chk("rst_left_y", left_y, 240);
        chk("rst_right_y", right_y, 240);
        chk("rst_left_valid", left_valid, 0);
        chk("rst_right_valid", right_valid, 0);
        chk("rst_strobe", frame_strobe, 0);

        vsync_edge();
        chk("arm_no_strobe", frame_strobe, 0);
        vsync_end();

        frame(100, 139, 100, 139, 10, 0, -1, 0, 0);
        vsync_edge();
        chk("b_left_y", left_y, L_B);
        chk("b_left_valid", left_valid, 1);
        chk("b_strobe", frame_strobe, 1);
        chk("b_right_valid", right_valid, 0);
        chk("b_right_y", right_y, 240);
        chk("model_b_left_y", exp_y[0], L_B);
        vsync_end();

        frame(300, 319, 0, -1, 0, 300, 319, 4, 0);
        vsync_edge();
        chk("c_right_valid", right_valid, 1);
        chk("c_right_y", right_y, R_C);
        chk("model_c_right_y", exp_y[1], R_C);
        vsync_end();

        for (int i = 1; i <= 8; i++) begin
            frame(200, 214, 0, -1, 0, 200, 214, 1, 0);
            vsync_edge();
            chk("miss_right_valid", right_valid, 0);
            chk("miss_strobe", frame_strobe, 1);
            if (i < 8) chk("miss_right_y_held", right_y, R_C);
            else       chk("miss_right_y_recentre", right_y, 240);
            vsync_end();
        end

        frame(200, 215, 0, -1, 0, 200, 215, 1, 0);
        vsync_edge();
        chk("b16_right_valid", right_valid, 1);
        chk("b16_right_y", right_y, R_B16);
        vsync_end();

        frame(100, 139, 100, 139, 10, 0, -1, 0, 1);
        vsync_edge();
        chk("blank_left_valid", left_valid, 0);
        chk("blank_strobe", frame_strobe, 1);
        vsync_end();

        frame(100, 139, 100, 139, 10, 0, -1, 0, 2);
        vsync_edge();
        chk("en_off_left_valid", left_valid, 0);
        vsync_end();

        frame(100, 104, 100, 139, 10, 0, -1, 0, 0);
        @(posedge clk); #2;
        reset = 1;
        #1;
        chk("midrst_right_y", right_y, 240);
        chk("midrst_left_valid", left_valid, 0);
        chk("midrst_strobe", frame_strobe, 0);
        @(posedge clk); #2;
        reset = 0;

        frame(90, 110, 90, 110, 2, 0, -1, 0, 0);
        vsync_edge();
        chk("post_rst_no_strobe", frame_strobe, 0);
        vsync_end();

        frame(90, 110, 90, 110, 2, 0, -1, 0, 0);
        vsync_edge();
        chk("post_rst_strobe", frame_strobe, 1);
        chk("post_rst_left_valid", left_valid, 1);
        chk("post_rst_left_y", left_y, L_F);
        chk("model_f_left_y", exp_y[0], L_F);
        vsync_end();

        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
